// File: rtl/functional_unit_pipe.sv
// functional_unit_pipe: 8-op functional unit, 2-stage valid/ready pipe.
// Stage 1 decodes and routes operands; stage 2 computes F/zero/carry.
module functional_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       instruction,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             zero,
  output logic             carry
);

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
  } s1_t;

  logic [2:0]       enc_op;
  s1_t              s1_d;
  s1_t              s1_q;
  logic             s1_valid;
  logic             s2_adv;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             cout;

  // Handshake: stage 2 drains when output is empty or being popped
  always_comb begin
    s2_adv   = s1_valid && (!out_valid || out_ready);
    in_ready = !s1_valid || s2_adv;
  end

  // Highest set instruction bit selects the op
  always_comb begin
    enc_op = 3'd0;
    priority case (1'b1)
      instruction[7]: enc_op = 3'd7;
      instruction[6]: enc_op = 3'd6;
      instruction[5]: enc_op = 3'd5;
      instruction[4]: enc_op = 3'd4;
      instruction[3]: enc_op = 3'd3;
      instruction[2]: enc_op = 3'd2;
      instruction[1]: enc_op = 3'd1;
      instruction[0]: enc_op = 3'd0;
      default:        enc_op = 3'd0;
    endcase
  end

  // Operand routing into X/Y
  always_comb begin
    s1_d.op = enc_op;
    s1_d.x  = C;
    s1_d.y  = A;
    unique case (select)
      3'b011: begin
        s1_d.x = B;
        s1_d.y = C;
      end
      3'b101: begin
        s1_d.x = A;
        s1_d.y = C;
      end
      3'b110: begin
        s1_d.x = A;
        s1_d.y = B;
      end
      default: begin
        s1_d.x = C;
        s1_d.y = A;
      end
    endcase
  end

  // Stage 1 register: loads whenever it is empty or draining
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  // Stage 2 datapath; shift binds before add, shifted-out bit lost
  always_comb begin
    sum  = '0;
    res  = '0;
    cout = 1'b0;
    unique case (s1_q.op)
      3'd7: res = (s1_q.x << 1) + s1_q.y;
      3'd6: res = (s1_q.x >> 1) + s1_q.y;
      3'd5: res = (s1_q.x < s1_q.y) ? s1_q.x : s1_q.y;
      3'd4: res = (s1_q.x > s1_q.y) ? s1_q.x : s1_q.y;
      3'd3: res = s1_q.x | s1_q.y;
      3'd2: res = s1_q.x & s1_q.y;
      3'd1: begin
        sum  = {1'b0, s1_q.x} + {1'b0, ~s1_q.y};
        res  = sum[WIDTH-1:0];
        cout = sum[WIDTH];
      end
      3'd0: begin
        sum  = {1'b0, s1_q.x} + {1'b0, s1_q.y};
        res  = sum[WIDTH-1:0];
        cout = sum[WIDTH];
      end
    endcase
  end

  // Output register: holds under stall, empties on pop without refill
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      F         <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= 1'b1;
      F         <= res;
      zero      <= (res == '0);
      carry     <= cout;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_functional_unit_pipe.sv
// tb_functional_unit_pipe: directed + random checks of functional_unit_pipe
// against an arithmetic reference model and in-order scoreboard.
module tb_functional_unit_pipe;

  localparam int W = 8;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   instr;
  logic [W-1:0] a, b, c;
  logic [2:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         zero;
  logic         carry;

  int checks   = 0;
  int failures = 0;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] e;

  functional_unit_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instr),
    .A(a), .B(b), .C(c),
    .select(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .F(f), .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {carry, zero, F} from the op rules with integer math
  function automatic logic [W+1:0] model(logic [7:0] ins, logic [2:0] s,
                                         logic [W-1:0] va, logic [W-1:0] vb,
                                         logic [W-1:0] vc);
    int op, x, y, r;
    bit cy;
    op = 0;
    cy = 1'b0;
    for (int i = 0; i < 8; i++) if (ins[i]) op = i;
    case (s)
      3'b011:  begin x = vb; y = vc; end
      3'b101:  begin x = va; y = vc; end
      3'b110:  begin x = va; y = vb; end
      default: begin x = vc; y = va; end
    endcase
    case (op)
      7: r = ((x * 2) % M + y) % M;
      6: r = (x / 2 + y) % M;
      5: r = (x < y) ? x : y;
      4: r = (x > y) ? x : y;
      3: r = x | y;
      2: r = x & y;
      1: begin r = x + (M - 1 - y); cy = (r >= M); r = r % M; end
      default: begin r = x + y; cy = (r >= M); r = r % M; end
    endcase
    return {cy, (r == 0), r[W-1:0]};
  endfunction

  // Scoreboard: push on accepted input, compare in order on each pop
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      exp_q.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_result", {carry, zero, f}, e);
        end
      end
      if (in_valid && in_ready === 1'b1)
        exp_q.push_back(model(instr, sel, a, b, c));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_chk(string tag, logic [7:0] ins, logic [2:0] s,
                          logic [W-1:0] va, logic [W-1:0] vb,
                          logic [W-1:0] vc, logic [W-1:0] ef,
                          logic ez, logic ec);
    int n;
    instr = ins; sel = s; a = va; b = vb; c = vc;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    cyc();
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < 8);
    chk({tag, "_latency"}, n, 2);
    chk({tag, "_F"}, f, ef);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_carry"}, carry, ec);
    cyc();
  endtask

  logic [W-1:0] f_hold;
  int acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; a = '0; b = '0; c = '0; sel = '0;
    cyc();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_F", f, 0);
    chk("rst_zero", zero, 0);
    chk("rst_carry", carry, 0);
    chk("rst_in_ready", in_ready, 1);
    cyc();

    send_chk("add", 8'h01, 3'b110, 8'h10, 8'h05, 8'h00, 8'h15, 0, 0);
    send_chk("shl_add", 8'h83, 3'b110, 8'h03, 8'h04, 8'h00, 8'h0A, 0, 0);
    send_chk("sub1", 8'h02, 3'b110, 8'h05, 8'h03, 8'h00, 8'h01, 0, 1);
    send_chk("add_wrap", 8'h00, 3'b000, 8'h01, 8'h00, 8'hFF, 8'h00, 1, 1);
    send_chk("min", 8'h20, 3'b101, 8'h7F, 8'h00, 8'h80, 8'h7F, 0, 0);
    send_chk("max", 8'h10, 3'b101, 8'h7F, 8'h00, 8'h80, 8'h80, 0, 0);
    send_chk("shr_add", 8'h40, 3'b011, 8'h00, 8'hFF, 8'h02, 8'h81, 0, 0);
    send_chk("or", 8'h08, 3'b110, 8'hF0, 8'h0F, 8'h00, 8'hFF, 0, 0);
    send_chk("and", 8'h04, 3'b110, 8'hF0, 8'h0F, 8'h00, 8'h00, 1, 0);

    // Stall: four offered, two accepted, output frozen
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      instr = 8'h01; sel = 3'b110;
      a = W'(i * 16 + 1); b = W'(i + 2);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready === 1'b1) acc++;
      if (i == 2) f_hold = f;
      cyc();
    end
    @(negedge clk);
    chk("stall_accepts", acc, 2);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_F_stable", f, f_hold);
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_1", out_valid, 1);
    cyc();
    @(negedge clk);
    chk("drain_2", out_valid, 1);
    cyc();
    @(negedge clk);
    chk("drain_empty", out_valid, 0);
    cyc();

    // Full throughput: accept every cycle while output pops
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      instr = 8'h01 << (i % 8); sel = 3'b110;
      a = W'($urandom); b = W'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready === 1'b1) acc++;
      cyc();
    end
    in_valid = 1'b0;
    chk("stream_accepts", acc, 6);
    repeat (4) cyc();

    // Reset with two transactions in flight
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      instr = 8'h01; sel = 3'b110; a = 8'h11; b = W'(i);
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_F", f, 0);
    chk("midrst_in_ready", in_ready, 1);
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale", out_valid, 0);
      cyc();
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 500; i++) begin
      case ($urandom % 4)
        0: instr = 8'($urandom);
        1: instr = 8'h00;
        default: instr = 8'h01 << $urandom_range(0, 7);
      endcase
      sel = 3'($urandom);
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) cyc();
    @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
